// File: rtl/udp_rx_filter_pkg.sv
// Shared types and protocol constants for the UDP receive filter.
// Optional VLAN support is enabled by defining UDP_RX_VLAN_EN.
package udp_rx_pkg;

  localparam int unsigned BYTE_CNT_W = 16;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int unsigned ETH_HDR_LEN    = 14;
  localparam int unsigned UDP_HDR_LEN    = 8;
  localparam int unsigned IP_MIN_IHL     = 5;
  localparam int unsigned VLAN_TAG_LEN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ETH,
    ST_IP,
    ST_UDP,
    ST_PAYLOAD,
    ST_DRAIN
`ifdef UDP_RX_VLAN_EN
    , ST_VLAN
`endif
  } state_e;

endpackage

// File: rtl/udp_rx_filter_if.sv
// Byte-stream handshake between the input FIFO, the filter and the output FIFO.
interface udp_rx_filter_if;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       in_sof;
  logic       in_eof;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;
  logic       out_sof;
  logic       out_eof;

  // Filter side
  modport slave (
    output in_rd_en, out_wr_en, out_din, out_sof, out_eof,
    input  in_empty, in_dout, in_sof, in_eof, out_full
  );

  // FIFO / environment side
  modport master (
    input  in_rd_en, out_wr_en, out_din, out_sof, out_eof,
    output in_empty, in_dout, in_sof, in_eof, out_full
  );
endinterface

// File: rtl/udp_rx_sat_counter.sv
// Saturating event counter used for the filter statistics.
module udp_rx_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count up on inc, hold at all-ones
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/udp_rx_filter.sv
// Ethernet/IPv4/UDP frame filter: forwards the UDP payload of matching
// frames, drains everything else, keeps saturating statistics.
// Define UDP_RX_VLAN_EN to accept single 802.1Q tagged frames.
module udp_rx_filter
  import udp_rx_pkg::*;
#(
  parameter logic [15:0]  DST_PORT = 16'd0,
  parameter int unsigned  CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  udp_rx_filter_if.slave   bus,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] trunc_count
);

  state_e                state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]            type_hi_q, type_hi_d;
  logic [3:0]            ihl_q, ihl_d;
  logic [7:0]            proto_q, proto_d;
  logic [15:0]           port_q, port_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           rem_q, rem_d;
  logic                  first_q, first_d;

  logic                  take_c;
  logic                  hdr_c;
  logic                  reject_c;
  logic                  rd_en_c, wr_en_c, sof_c, eof_c;
  logic                  inc_pkt_c, inc_drop_c, inc_trunc_c;
  logic [15:0]           type_c;
  logic [15:0]           ip_last_c;

  assign take_c    = !bus.in_empty;
  assign type_c    = {type_hi_q, bus.in_dout};
  assign ip_last_c = {10'd0, ihl_q, 2'b00} - 16'd1;

  // Next-state, capture and handshake decode
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    type_hi_d   = type_hi_q;
    ihl_d       = ihl_q;
    proto_d     = proto_q;
    port_d      = port_q;
    len_d       = len_q;
    rem_d       = rem_q;
    first_d     = first_q;
    hdr_c       = 1'b0;
    reject_c    = 1'b0;
    rd_en_c     = 1'b0;
    wr_en_c     = 1'b0;
    sof_c       = 1'b0;
    eof_c       = 1'b0;
    inc_pkt_c   = 1'b0;
    inc_drop_c  = 1'b0;
    inc_trunc_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take_c) begin
          if (bus.in_sof) begin
            state_d    = ST_ETH;
            byte_cnt_d = '0;
          end else begin
            rd_en_c = 1'b1;
          end
        end
      end

      ST_ETH: begin
        hdr_c = 1'b1;
        if (take_c) begin
          rd_en_c    = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == 16'(ETH_HDR_LEN - 2)) type_hi_d = bus.in_dout;
          if (byte_cnt_q == 16'(ETH_HDR_LEN - 1)) begin
            byte_cnt_d = '0;
            if (type_c == ETHERTYPE_IPV4) begin
              state_d = ST_IP;
`ifdef UDP_RX_VLAN_EN
            end else if (type_c == ETHERTYPE_VLAN) begin
              state_d = ST_VLAN;
`else
            end else if (type_c == ETHERTYPE_VLAN) begin
              reject_c = 1'b1;  // tagged frames unsupported in this build
`endif
            end else begin
              reject_c = 1'b1;
            end
          end
        end
      end

`ifdef UDP_RX_VLAN_EN
      ST_VLAN: begin
        hdr_c = 1'b1;
        if (take_c) begin
          rd_en_c    = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == 16'(VLAN_TAG_LEN - 2)) type_hi_d = bus.in_dout;
          if (byte_cnt_q == 16'(VLAN_TAG_LEN - 1)) begin
            byte_cnt_d = '0;
            if (type_c == ETHERTYPE_IPV4) state_d = ST_IP;
            else                          reject_c = 1'b1;
          end
        end
      end
`endif

      ST_IP: begin
        hdr_c = 1'b1;
        if (take_c) begin
          rd_en_c    = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (byte_cnt_q == 16'd0) begin
            ihl_d = bus.in_dout[3:0];
            if ((bus.in_dout[7:4] != 4'd4) || (bus.in_dout[3:0] < 4'(IP_MIN_IHL)))
              reject_c = 1'b1;
          end else if (byte_cnt_q == ip_last_c) begin
            byte_cnt_d = '0;
            if (proto_q == IP_PROTO_UDP) state_d = ST_UDP;
            else                         reject_c = 1'b1;
          end
          if (byte_cnt_q == 16'd9) proto_d = bus.in_dout;
        end
      end

      ST_UDP: begin
        hdr_c = 1'b1;
        if (take_c) begin
          rd_en_c    = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          case (byte_cnt_q)
            16'd2:   port_d[15:8] = bus.in_dout;
            16'd3:   port_d[7:0]  = bus.in_dout;
            16'd4:   len_d[15:8]  = bus.in_dout;
            16'd5:   len_d[7:0]   = bus.in_dout;
            default: ;
          endcase
          if (byte_cnt_q == 16'(UDP_HDR_LEN - 1)) begin
            byte_cnt_d = '0;
            if ((DST_PORT != 16'd0) && (port_q != DST_PORT)) begin
              reject_c = 1'b1;
            end else if (len_q <= 16'(UDP_HDR_LEN)) begin
              reject_c = 1'b1;
            end else begin
              state_d = ST_PAYLOAD;
              rem_d   = len_q - 16'(UDP_HDR_LEN);
              first_d = 1'b1;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (take_c && !bus.out_full) begin
          rd_en_c = 1'b1;
          wr_en_c = 1'b1;
          sof_c   = first_q;
          first_d = 1'b0;
          rem_d   = rem_q - 16'd1;
          if ((rem_q == 16'd1) || bus.in_eof) begin
            eof_c       = 1'b1;
            inc_pkt_c   = 1'b1;
            inc_trunc_c = (rem_q != 16'd1);
            state_d     = bus.in_eof ? ST_IDLE : ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (take_c) begin
          rd_en_c = 1'b1;
          if (bus.in_eof) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A rejected header or an early end of frame inside a header is one drop
    if (reject_c || (hdr_c && take_c && bus.in_eof)) begin
      inc_drop_c = 1'b1;
      state_d    = bus.in_eof ? ST_IDLE : ST_DRAIN;
    end
  end

  // State and header field registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      type_hi_q  <= '0;
      ihl_q      <= '0;
      proto_q    <= '0;
      port_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      type_hi_q  <= type_hi_d;
      ihl_q      <= ihl_d;
      proto_q    <= proto_d;
      port_q     <= port_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
    end
  end

  // Payload is a zero-latency pass-through; everything is quiet in reset
  assign bus.in_rd_en  = rd_en_c && !reset;
  assign bus.out_wr_en = wr_en_c && !reset;
  assign bus.out_din   = (wr_en_c && !reset) ? bus.in_dout : 8'h00;
  assign bus.out_sof   = sof_c && !reset;
  assign bus.out_eof   = eof_c && !reset;

  udp_rx_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_pkt_c && !reset),
    .count (pkt_count)
  );

  udp_rx_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_drop_c && !reset),
    .count (drop_count)
  );

  udp_rx_sat_counter #(.CNT_W(CNT_W)) u_trunc_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (inc_trunc_c && !reset),
    .count (trunc_count)
  );

endmodule

// File: tb/tb_udp_rx_filter.sv
// Randomised bench for udp_rx_filter with a frame-level reference model.
module tb_udp_rx_filter;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [15:0] PORT    = 16'd5000;
`ifdef UDP_RX_VLAN_EN
  localparam int VLAN_FWD = 1;
`else
  localparam int VLAN_FWD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_rx_filter_if bus();
  logic [CNT_W-1:0] pkt_count, drop_count, trunc_count;

  udp_rx_filter #(.DST_PORT(PORT), .CNT_W(CNT_W)) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .pkt_count   (pkt_count),
    .drop_count  (drop_count),
    .trunc_count (trunc_count)
  );

  // {sof, eof, byte}
  logic [9:0] in_q[$];
  logic [9:0] exp_q[$];
  int m_pkt = 0, m_drop = 0, m_trunc = 0;
  int tests = 0, fails = 0;
  int full_mode = 2;   // 0 random, 1 toggle, 2 never full
  int stall_pct = 0;
  logic tog = 1'b0;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Reference model: decide a whole frame's fate from its bytes
  task automatic model_frame(input logic [7:0] f[$]);
    int n, off, et, hl, ue, rem, plen, udpl, port;
    bit ok;
    n = f.size(); ok = 1'b1; off = 14; hl = 0; udpl = 0; port = 0; ue = 0;
    if (n < 14) ok = 1'b0;
    else begin
      et = {f[12], f[13]};
`ifdef UDP_RX_VLAN_EN
      if (et == 'h8100) begin
        off = 18;
        if (n < 18) ok = 1'b0;
        else et = {f[16], f[17]};
      end
`endif
      if (et != 'h0800) ok = 1'b0;
    end
    if (ok && n <= off) ok = 1'b0;
    if (ok) begin
      if (f[off][7:4] != 4'd4 || f[off][3:0] < 4'd5) ok = 1'b0;
      else hl = int'(f[off][3:0]) * 4;
    end
    if (ok) begin
      ue = off + hl + 8;
      if (n <= ue) ok = 1'b0;
    end
    if (ok) begin
      port = {f[off+hl+2], f[off+hl+3]};
      udpl = {f[off+hl+4], f[off+hl+5]};
      if (f[off+9] != 8'h11 || port != int'(PORT) || udpl <= 8) ok = 1'b0;
    end
    if (!ok) m_drop++;
    else begin
      rem  = udpl - 8;
      plen = (n - ue < rem) ? n - ue : rem;
      for (int i = 0; i < plen; i++)
        exp_q.push_back({i == 0, i == plen - 1, f[ue+i]});
      m_pkt++;
      if (n - ue < rem) m_trunc++;
    end
  endtask

  task automatic make_frame(output logic [7:0] f[$], input int et, input bit vlan,
                            input int ihl, input int proto, input int port,
                            input int udpl, input int npay, input int npad);
    int iplen;
    f = {};
    for (int i = 0; i < 12; i++) f.push_back(8'($urandom));
    if (vlan) begin
      f.push_back(8'h81); f.push_back(8'h00);
      f.push_back(8'($urandom)); f.push_back(8'($urandom));
    end
    f.push_back(8'(et >> 8)); f.push_back(8'(et));
    f.push_back({4'h4, 4'(ihl)});
    iplen = (ihl >= 5) ? ihl * 4 : 20;
    for (int i = 1; i < iplen; i++) f.push_back((i == 9) ? 8'(proto) : 8'($urandom));
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    f.push_back(8'(port >> 8)); f.push_back(8'(port));
    f.push_back(8'(udpl >> 8)); f.push_back(8'(udpl));
    f.push_back(8'($urandom)); f.push_back(8'($urandom));
    for (int i = 0; i < npay + npad; i++) f.push_back(8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    model_frame(f);
    repeat ($urandom_range(0, 2))
      in_q.push_back({1'b0, 1'($urandom_range(1)), 8'($urandom)});
    for (int i = 0; i < f.size(); i++)
      in_q.push_back({i == 0, i == f.size() - 1, f[i]});
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    check("drain_timeout", int'(cyc >= 4000), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkt"},   int'(pkt_count),   sat(m_pkt));
    check({tag, "_drop"},  int'(drop_count),  sat(m_drop));
    check({tag, "_trunc"}, int'(trunc_count), sat(m_trunc));
  endtask

  // Input FIFO and output-full driver
  initial begin
    bus.in_empty = 1'b1; bus.in_dout = 8'h00; bus.in_sof = 1'b0;
    bus.in_eof = 1'b0; bus.out_full = 1'b0;
    forever begin
      @(negedge clk);
      if (in_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
        bus.in_empty = 1'b0;
        {bus.in_sof, bus.in_eof, bus.in_dout} = in_q[0];
      end else begin
        bus.in_empty = 1'b1;
        {bus.in_sof, bus.in_eof, bus.in_dout} = 10'($urandom);
      end
      case (full_mode)
        0:       bus.out_full = ($urandom_range(3) == 0);
        1:       begin tog = ~tog; bus.out_full = tog; end
        default: bus.out_full = 1'b0;
      endcase
      #3;
      if (bus.in_rd_en && !bus.in_empty) void'(in_q.pop_front());
    end
  end

  // Output compare against the model, plus handshake rules
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (bus.out_wr_en) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write actual=%h expected=none",
                     {bus.out_sof, bus.out_eof, bus.out_din});
          end else begin
            e = exp_q.pop_front();
            if ({bus.out_sof, bus.out_eof, bus.out_din} != e) begin
              fails++;
              $display("FAIL out_byte actual=%h expected=%h",
                       {bus.out_sof, bus.out_eof, bus.out_din}, e);
            end
          end
        end
        tests++;
        if ((bus.in_rd_en && bus.in_empty) || (bus.out_wr_en && bus.out_full) ||
            (bus.out_wr_en && !bus.in_rd_en) ||
            (bus.out_wr_en && bus.out_din != bus.in_dout)) begin
          fails++;
          $display("FAIL handshake actual=rd%0b/wr%0b/empty%0b/full%0b expected=legal",
                   bus.in_rd_en, bus.out_wr_en, bus.in_empty, bus.out_full);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    int kind, ihl, npay, udpl, npad, et, proto, port, cut;
    bit vl;

    rst = 1'b1;
    in_q.push_back({1'b0, 1'b0, 8'h5A});
    repeat (3) @(negedge clk);
    #4;
    check("rst_rd_en",  int'(bus.in_rd_en),  0);
    check("rst_wr_en",  int'(bus.out_wr_en), 0);
    check("rst_din",    int'(bus.out_din),   0);
    check("rst_counts", int'(pkt_count) + int'(drop_count) + int'(trunc_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame with padding
    make_frame(f, 'h0800, 1'b0, 5, 'h11, PORT, 12, 4, 14);
    f[42] = 8'hAA; f[43] = 8'hBB; f[44] = 8'hCC; f[45] = 8'hDD;
    send_frame(f);
    check("m1_len",   exp_q.size(), 4);
    check("m1_first", int'(exp_q[0]), 'h2AA);
    check("m1_last",  int'(exp_q[3]), 'h1DD);
    wait_idle();
    check("t1_pkt", int'(pkt_count), 1);
    check_counts("t1");

    // IP options, port match then mismatch
    make_frame(f, 'h0800, 1'b0, 7, 'h11, PORT, 20, 12, 3);
    send_frame(f);
    make_frame(f, 'h0800, 1'b0, 7, 'h11, PORT + 1, 20, 12, 3);
    send_frame(f);
    wait_idle();
    check("t2_pkt",  int'(pkt_count),  2);
    check("t2_drop", int'(drop_count), 1);

    // Wrong EtherType, wrong protocol, empty UDP, then a good frame
    make_frame(f, 'h86DD, 1'b0, 5, 'h11, PORT, 20, 12, 0); send_frame(f);
    make_frame(f, 'h0800, 1'b0, 5, 'h06,  PORT, 20, 12, 0); send_frame(f);
    make_frame(f, 'h0800, 1'b0, 5, 'h11, PORT, 8, 0, 6);   send_frame(f);
    make_frame(f, 'h0800, 1'b0, 5, 'h11, PORT, 9, 1, 0);   send_frame(f);
    wait_idle();
    check("t3_pkt",  int'(pkt_count),  3);
    check("t3_drop", int'(drop_count), 4);

    // Truncated payload
    make_frame(f, 'h0800, 1'b0, 5, 'h11, PORT, 100, 10, 0);
    send_frame(f);
    check("m4_last", int'(exp_q[9][8]), 1);
    wait_idle();
    check("t4_trunc", int'(trunc_count), 1);
    check("t4_pkt",   int'(pkt_count),   4);

    // Back-pressure toggling every cycle on a 64-byte payload
    full_mode = 1;
    make_frame(f, 'h0800, 1'b0, 5, 'h11, PORT, 72, 64, 5);
    send_frame(f);
    check("m5_len", exp_q.size(), 64);
    wait_idle();
    check("t5_pkt", int'(pkt_count), 5);
    full_mode = 2;

    // VLAN-tagged frame
    make_frame(f, 'h0800, 1'b1, 5, 'h11, PORT, 16, 8, 2);
    send_frame(f);
    wait_idle();
    check("t6_pkt",  int'(pkt_count),  5 + VLAN_FWD);
    check("t6_drop", int'(drop_count), 5 - VLAN_FWD);
    check_counts("t6");

    // Random mix with stalls on both sides; counters saturate here
    full_mode = 0;
    stall_pct = 20;
    for (int k = 0; k < 40; k++) begin
      kind  = $urandom_range(9);
      ihl   = $urandom_range(5, 15);
      npay  = $urandom_range(1, 40);
      udpl  = npay + 8;
      npad  = $urandom_range(0, 6);
      et    = 'h0800;
      proto = 'h11;
      port  = PORT;
      vl    = 1'b0;
      cut   = 0;
      case (kind)
        0: et    = $urandom_range(0, 'hFFFF);
        1: proto = 'h06;
        2: port  = PORT + 1;
        3: udpl  = $urandom_range(0, 8);
        4: udpl  = npay + 8 + $urandom_range(1, 20);
        5: ihl   = $urandom_range(0, 4);
        6: cut   = $urandom_range(1, 60);
        7: vl    = 1'b1;
        default: ;
      endcase
      make_frame(f, et, vl, ihl, proto, port, udpl, npay, npad);
      if (cut != 0) while (f.size() > cut) void'(f.pop_back());
      send_frame(f);
      if (k % 8 == 7) begin
        wait_idle();
        check_counts("rand");
      end
    end
    wait_idle();
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_rx_filter.md
# udp_rx_filter

Parametrised successor to the byte-stream UDP parser. Sits between two byte FIFO controllers, takes Ethernet frames and emits only the UDP payload of IPv4/UDP frames whose destination port matches. Handles variable-length IPv4 headers (IHL), trims Ethernet padding using the UDP length, and keeps saturating pass/drop statistics.

## Interface
- `DST_PORT`, default 16'd0: UDP destination port to accept; 0 = accept any port.
- `CNT_W`, default 16: width of the statistics counters.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_rd_en`, out, 1: consume the current input byte.
- `in_empty`, in, 1: input FIFO empty.
- `in_dout`, in, 8: input byte (first-word-fall-through, valid when `!in_empty`).
- `in_sof`, in, 1: current input byte is the first of a frame.
- `in_eof`, in, 1: current input byte is the last of a frame.
- `out_wr_en`, out, 1: write `out_din` to the output FIFO.
- `out_full`, in, 1: output FIFO full.
- `out_din`, out, 8: payload byte.
- `out_sof`, out, 1: first payload byte of a packet.
- `out_eof`, out, 1: last payload byte of a packet.
- `pkt_count`, out, CNT_W: packets forwarded (saturating).
- `drop_count`, out, CNT_W: frames dropped (saturating).
- `trunc_count`, out, CNT_W: packets cut short by an early `in_eof` (saturating).

## Operation
- A byte is consumed when `in_rd_en && !in_empty`. `in_rd_en` is never asserted while `in_empty`.
- `out_wr_en` is never asserted while `out_full`.
- States: IDLE, ETH, VLAN (macro only), IP, UDP, PAYLOAD, DRAIN. A 16-bit `byte_cnt` counts bytes within the current header.
- IDLE: discard non-SOF bytes. On an SOF byte, go to ETH without consuming it. `in_sof` is examined only in IDLE.
- ETH: consume 14 bytes and capture the EtherType at bytes 12-13. At byte 13, evaluate the full type (the registered high byte plus the current `in_dout`):
  - 0x0800 → IP.
  - anything else → drop.
- IP: at byte 0, require version nibble 4 and IHL ≥ 5, else drop. Header length is IHL×4 (20..60 bytes); options are skipped. Capture the protocol at byte 9. At the last header byte, go to UDP if protocol = 0x11, else drop.
- UDP: consume 8 bytes. Capture the destination port at bytes 2-3 and the length at bytes 4-5. At byte 7:
  - port mismatch (when `DST_PORT` ≠ 0) → drop.
  - length ≤ 8 → drop.
  - otherwise → PAYLOAD, with remaining = length − 8.
- PAYLOAD:
  - `in_rd_en = out_wr_en = !in_empty && !out_full`; `out_din = in_dout`.
  - `out_sof` is asserted on the first written byte.
  - `out_eof` is asserted when remaining = 1, or when `in_eof` arrives earlier (truncation; `trunc_count`++).
  - `pkt_count` increments on the `out_eof` write.
  - Next state: IDLE if the byte carried `in_eof`, else DRAIN (padding).
- Drop: `drop_count`++ once per frame. Next state: IDLE if the deciding byte carried `in_eof`, else DRAIN.
- An `in_eof` inside any header state counts as a drop and returns to IDLE.
- DRAIN: consume bytes until one with `in_eof`, then go to IDLE.
- Counters saturate at all-ones.

## Timing
- Reset: state IDLE. All outputs 0: `in_rd_en`, `out_wr_en`, `out_din`, `out_sof`, `out_eof`, and all counters.
- Throughput is 1 byte/cycle in every state except the single non-consuming IDLE→ETH cycle.
- Payload path is combinational: zero-cycle latency from `in_dout` to `out_din`.
- Counters update on the clock edge after the deciding byte.
- `out_full` stalls PAYLOAD only; header and DRAIN states ignore `out_full`.
- `reset` mid-frame returns to IDLE the next cycle. The partial frame is not counted. A packet whose `out_sof` was already written is left open downstream.

## Configuration
- `UDP_RX_VLAN_EN` defined:
  - EtherType 0x8100 at bytes 12-13 → VLAN state.
  - VLAN consumes 4 bytes: TCI, then the inner EtherType.
  - The inner EtherType gets the same 0x0800 check as ETH.
- `UDP_RX_VLAN_EN` undefined: 0x8100 frames are dropped; the VLAN state does not exist.

## Structure
- Package `udp_rx_pkg`:
  - state enum.
  - constants: `ETHERTYPE_IPV4` = 16'h0800, `ETHERTYPE_VLAN` = 16'h8100, `IP_PROTO_UDP` = 8'h11, `ETH_HDR_LEN` = 14, `UDP_HDR_LEN` = 8, `IP_MIN_IHL` = 5.
- Sub-module `udp_rx_sat_counter`: parameter CNT_W; inputs `clock`, `reset`, `inc`; output `count`. Instantiated three times.

## Test plan
- IPv4/UDP frame, IHL 5, UDP length 12, 4 payload bytes AA BB CC DD, 14 padding bytes → 4 writes, SOF on AA, EOF on DD; padding drained; `pkt_count` = 1.
- IHL 7 (8 option bytes), `DST_PORT` = 5000, frame with port 5000 then frame with port 5001 → first forwarded, second dropped; `pkt_count` = 1, `drop_count` = 1.
- EtherType 0x86DD frame, then protocol 0x06 frame, then UDP length 8 frame → no writes; `drop_count` = 3; next valid frame forwarded.
- UDP length 100 but `in_eof` after 10 payload bytes → 10 writes, EOF on the 10th; `trunc_count` = 1.
- `out_full` toggled every other cycle during a 64-byte payload → all 64 bytes emitted in order with no loss or duplication; `in_rd_en` is never high while `out_full`.
- VLAN-tagged frame (0x8100, TCI, 0x0800) → forwarded with `UDP_RX_VLAN_EN`, dropped without it.
